// File: rtl/imem_dmem_arbiter.sv
// Fixed-priority (D over IF) arbiter for the unified single-ported memory of femtoRV32.
// It serialises fetch and load/store accesses and returns read data through holding registers.
module imem_dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_D    = 2'd1,
    SEL_IF   = 2'd2
  } sel_e;

  sel_e              sel_s;
  logic              elig_if_s;
  logic              elig_d_s;
  logic              accept_s;
  logic              p_if_r;
  logic              p_d_r;
  logic              r1_valid_r;
  logic              r1_is_d_r;
  logic              r1_we_r;
  logic              if_valid_r;
  logic              d_done_r;
  logic [DATA_W-1:0] if_rdata_r;
  logic [DATA_W-1:0] d_rdata_r;

  assign elig_if_s = if_req && !p_if_r;
  assign elig_d_s  = d_req && !p_d_r;
  assign accept_s  = (sel_s != SEL_NONE) && mem_ready;

  // Port selection; gating on rst_n keeps the memory idle while in reset
  always_comb begin
    sel_s = SEL_NONE;
    if (!rst_n) begin
      sel_s = SEL_NONE;
    end else if (elig_d_s) begin
      sel_s = SEL_D;
    end else if (elig_if_s) begin
      sel_s = SEL_IF;
    end else begin
      sel_s = SEL_NONE;
    end
  end

  // Drive the memory port from the selected requester
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = 4'h0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (sel_s)
      SEL_D: begin
        mem_en    = 1'b1;
        mem_we    = d_we;
        mem_be    = d_we ? d_be : 4'hF;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
      end
      SEL_IF: begin
        mem_en   = 1'b1;
        mem_be   = 4'hF;
        mem_addr = if_addr;
      end
      default: begin
        mem_en = 1'b0;
      end
    endcase
  end

  // Pending flags: set on acceptance, cleared at the end of the completion pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_if_r <= 1'b0;
      p_d_r  <= 1'b0;
    end else begin
      if (accept_s && (sel_s == SEL_IF)) begin
        p_if_r <= 1'b1;
      end else if (if_valid_r) begin
        p_if_r <= 1'b0;
      end else begin
        p_if_r <= p_if_r;
      end
      if (accept_s && (sel_s == SEL_D)) begin
        p_d_r <= 1'b1;
      end else if (d_done_r) begin
        p_d_r <= 1'b0;
      end else begin
        p_d_r <= p_d_r;
      end
    end
  end

  // Response pipeline: R1 tags the accepted access and captures read data, R2 pulses completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_valid_r <= 1'b0;
      r1_is_d_r  <= 1'b0;
      r1_we_r    <= 1'b0;
      if_valid_r <= 1'b0;
      d_done_r   <= 1'b0;
      if_rdata_r <= '0;
      d_rdata_r  <= '0;
    end else begin
      r1_valid_r <= accept_s;
      r1_is_d_r  <= (sel_s == SEL_D);
      r1_we_r    <= mem_we;
      if_valid_r <= r1_valid_r && !r1_is_d_r;
      d_done_r   <= r1_valid_r && r1_is_d_r;
      if (r1_valid_r && !r1_we_r && r1_is_d_r) begin
        d_rdata_r <= mem_rdata;
      end else if (r1_valid_r && !r1_we_r) begin
        if_rdata_r <= mem_rdata;
      end else begin
        d_rdata_r <= d_rdata_r;
      end
    end
  end

  assign if_rdata = if_rdata_r;
  assign d_rdata  = d_rdata_r;
  assign if_valid = if_valid_r;
  assign d_done   = d_done_r;
  assign busy     = p_if_r | p_d_r;

endmodule
